// File: rtl/pisa_pkg.sv
// Shared PISA types: decoder control word, its field enums and the sequencer state.
package pisa_pkg;

  typedef enum logic [1:0] {
    RegSrcNone   = 2'd0,
    RegSrcAlu    = 2'd1,
    RegSrcMemory = 2'd2,
    RegSrcImm    = 2'd3
  } write_register_src_t;

  typedef enum logic {
    MemSrcNone  = 1'b0,
    MemSrcRsrc1 = 1'b1
  } write_memory_src_t;

  typedef enum logic {
    AddrImm   = 1'b0,
    AddrRsrc2 = 1'b1
  } memory_address_src_t;

  typedef enum logic [1:0] {
    JmpNone = 2'd0,
    JmpImm  = 2'd1,
    JmpRsrc = 2'd2
  } jmp_src_t;

  // Codes 001, 110 and 111 are undefined and evaluate as not taken.
  typedef enum logic [2:0] {
    CondAlways        = 3'b000,
    CondIfZero        = 3'b010,
    CondIfNotZero     = 3'b011,
    CondIfNegative    = 3'b100,
    CondIfNotNegative = 3'b101
  } jump_condition_t;

  typedef struct packed {
    logic                halt;
    write_register_src_t write_register_src;
    write_memory_src_t   write_memory_src;
    memory_address_src_t memory_address_src;
    jmp_src_t            jmp_src;
    jump_condition_t     jump_condition;
  } control_signal_t;

  typedef enum logic [2:0] {
    StFetch,
    StFetchWait,
    StDecode,
    StExecute,
    StMem,
    StMemWait,
    StWriteback,
    StHalted
  } seq_state_t;

  function automatic logic cs_is_store(control_signal_t c);
    return c.write_memory_src != MemSrcNone;
  endfunction

  // A store takes priority if a control word ever requests both.
  function automatic logic cs_is_load(control_signal_t c);
    return (c.write_register_src == RegSrcMemory) && !cs_is_store(c);
  endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational branch condition evaluation from the Z/N flags.
module jump_cond_eval
  import pisa_pkg::*;
(
  input  jump_condition_t jump_condition,
  input  logic            flag_z,
  input  logic            flag_n,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (jump_condition)
      CondAlways:        taken = 1'b1;
      CondIfZero:        taken = flag_z;
      CondIfNotZero:     taken = !flag_z;
      CondIfNegative:    taken = flag_n;
      CondIfNotNegative: taken = !flag_n;
      default:           taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pisa_sequencer.sv
// Multi-cycle PISA sequencer: owns PC/IR/MDR/flags and drives the shared memory port.
module pisa_sequencer
  import pisa_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  control_signal_t cs,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] jump_target,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_write,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] mdr,
  output logic            rf_we,
  output logic            flag_z,
  output logic            flag_n,
  output logic            halted
);

  seq_state_t state;
  logic       taken;
  logic       is_store;
  logic       is_load;
  logic       writes_reg;

  // The address source is already resolved into data_addr by the datapath.
  logic unused_addr_src;
  assign unused_addr_src = cs.memory_address_src;

  assign is_store   = cs_is_store(cs);
  assign is_load    = cs_is_load(cs);
  assign writes_reg = cs.write_register_src != RegSrcNone;

  jump_cond_eval u_jump_cond_eval (
    .jump_condition (cs.jump_condition),
    .flag_z         (flag_z),
    .flag_n         (flag_n),
    .taken          (taken)
  );

  // Request fields are decoded from state; address/data are the held datapath values.
  always_comb begin
    mem_req_valid = (state == StFetch) || (state == StMem);
    mem_req_write = (state == StMem) && is_store;
    mem_req_addr  = (state == StMem) ? data_addr : pc;
    mem_req_wdata = mem_req_write ? store_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StFetch;
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      rf_we  <= 1'b0;
      halted <= 1'b0;
    end else begin
      // rf_we is set on entry to WRITEBACK so it is high for exactly that cycle.
      rf_we <= 1'b0;
      unique case (state)
        StFetch: begin
          if (mem_req_ready) state <= StFetchWait;
        end
        StFetchWait: begin
          if (mem_rsp_valid) begin
            ir    <= mem_rsp_data;
            state <= StDecode;
          end
        end
        StDecode: begin
          if (cs.halt) begin
            state  <= StHalted;
            halted <= 1'b1;
          end else begin
            state <= StExecute;
          end
        end
        StExecute: begin
          if (is_store || is_load) begin
            state <= StMem;
          end else begin
            state <= StWriteback;
            rf_we <= writes_reg;
          end
        end
        StMem: begin
          if (mem_req_ready) begin
            if (is_store) begin
              state <= StWriteback;
              rf_we <= writes_reg;
            end else begin
              state <= StMemWait;
            end
          end
        end
        StMemWait: begin
          if (mem_rsp_valid) begin
            mdr   <= mem_rsp_data;
            state <= StWriteback;
            rf_we <= writes_reg;
          end
        end
        StWriteback: begin
          if (cs.write_register_src == RegSrcAlu) begin
            flag_z <= (alu_result == '0);
            flag_n <= alu_result[XLEN-1];
          end
          if ((cs.jmp_src != JmpNone) && taken) pc <= jump_target;
          else                                  pc <= pc + XLEN'(INSTR_BYTES);
          state <= StFetch;
        end
        StHalted: begin
          state <= StHalted;
        end
        default: state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_pisa_sequencer.sv
// Self-checking bench: directed table, randomized instructions vs. a reference model,
// plus reset and halt sequences.
module tb_pisa_sequencer;
  import pisa_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  control_signal_t cs;
  logic [31:0]     alu_result, data_addr, store_data, jump_target;
  logic            mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]     mem_req_addr, mem_req_wdata;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic [31:0]     pc, ir, mdr;
  logic            rf_we, flag_z, flag_n, halted;

  always #5 clk = ~clk;

  pisa_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cs            (cs),
    .alu_result    (alu_result),
    .data_addr     (data_addr),
    .store_data    (store_data),
    .jump_target   (jump_target),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .pc            (pc),
    .ir            (ir),
    .mdr           (mdr),
    .rf_we         (rf_we),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .halted        (halted)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural reference state
  logic [31:0] m_pc, m_ir, m_mdr;
  bit          m_z, m_n;

  typedef struct {
    control_signal_t c;
    logic [31:0]     alu, daddr, sdata, jtgt, rdata;
    int              rd1, rs1, rd2, rs2;
    logic [31:0]     exp_pc;
    bit              exp_z, exp_n;
    logic [31:0]     exp_mdr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic control_signal_t mkcs(input bit h, input write_register_src_t w,
                                           input write_memory_src_t m, input jmp_src_t j,
                                           input logic [2:0] cond);
    control_signal_t c;
    c.halt               = h;
    c.write_register_src = w;
    c.write_memory_src   = m;
    c.memory_address_src = AddrImm;
    c.jmp_src            = j;
    c.jump_condition     = jump_condition_t'(cond);
    return c;
  endfunction

  function automatic bit model_taken(input logic [2:0] cond, input bit z, input bit n);
    if (cond == 3'd0) return 1'b1;
    if (cond == 3'd2) return z;
    if (cond == 3'd3) return !z;
    if (cond == 3'd4) return n;
    if (cond == 3'd5) return !n;
    return 1'b0;
  endfunction

  // One clock cycle: drive memory side, check outputs, advance to next negedge.
  task automatic cyc(input bit ereq, input bit ewr, input logic [31:0] eaddr,
                     input logic [31:0] ewd, input bit erfwe, input bit ehalt,
                     input bit rdy, input bit rspv, input logic [31:0] rdata);
    mem_req_ready = rdy;
    mem_rsp_valid = rspv;
    mem_rsp_data  = rdata;
    #1;
    chk1("req_valid", mem_req_valid, ereq);
    if (ereq) begin
      chk("req_addr", mem_req_addr, eaddr);
      chk1("req_write", mem_req_write, ewr);
      if (ewr) chk("req_wdata", mem_req_wdata, ewd);
    end
    chk1("rf_we", rf_we, erfwe);
    chk1("halted", halted, ehalt);
    @(negedge clk);
  endtask

  task automatic check_arch();
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chk("mdr", mdr, m_mdr);
    chk1("flag_z", flag_z, m_z);
    chk1("flag_n", flag_n, m_n);
  endtask

  task automatic run_instr(input control_signal_t c, input logic [31:0] iw,
                           input logic [31:0] alu, input logic [31:0] daddr,
                           input logic [31:0] sdata, input logic [31:0] jtgt,
                           input logic [31:0] rdata, input int rd1, input int rs1,
                           input int rd2, input int rs2);
    bit st, ld, tk;
    cs = c; alu_result = alu; data_addr = daddr; store_data = sdata; jump_target = jtgt;
    st = c.write_memory_src != MemSrcNone;
    ld = !st && (c.write_register_src == RegSrcMemory);
    // Junk responses while requesting must be ignored, including in the ready cycle.
    for (int i = 0; i <= rd1; i++)
      cyc(1, 0, m_pc, 0, 0, 0, i == rd1, 1'($urandom_range(0, 1)), $urandom);
    for (int i = 0; i <= rs1; i++)
      cyc(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), i == rs1, (i == rs1) ? iw : $urandom);
    m_ir = iw;
    chk("ir_fetch", ir, m_ir);
    cyc(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom);
    if (c.halt) begin
      for (int i = 0; i < 20; i++)
        cyc(0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      check_arch();
      return;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom);
    if (st || ld)
      for (int i = 0; i <= rd2; i++)
        cyc(1, st, daddr, sdata, 0, 0, i == rd2, 1'($urandom_range(0, 1)), $urandom);
    if (ld) begin
      for (int i = 0; i <= rs2; i++)
        cyc(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), i == rs2,
            (i == rs2) ? rdata : $urandom);
      m_mdr = rdata;
    end
    cyc(0, 0, 0, 0, c.write_register_src != RegSrcNone, 0, 0, 0, 0);
    tk = (c.jmp_src != JmpNone) && model_taken(c.jump_condition, m_z, m_n);
    m_pc = tk ? jtgt : m_pc + 32'd4;
    if (c.write_register_src == RegSrcAlu) begin
      m_z = (alu == 32'd0);
      m_n = alu[31];
    end
    check_arch();
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_mdr = 32'd0; m_z = 0; m_n = 0;
  endtask

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0;
    cs = mkcs(0, RegSrcNone, MemSrcNone, JmpNone, 3'd0);
    alu_result = 0; data_addr = 0; store_data = 0; jump_target = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    model_reset();

    //            cs                                                  alu          daddr
    tbl[0]  = '{mkcs(0, RegSrcAlu, MemSrcNone, JmpNone, 3'd0), 32'h0, 32'h0,
                32'h0, 32'h999, 32'h0, 0, 0, 0, 0, 32'h4, 1, 0, 32'h0};
    tbl[1]  = '{mkcs(0, RegSrcMemory, MemSrcNone, JmpNone, 3'd0), 32'h7, 32'h100,
                32'h0, 32'h0, 32'hDEAD, 0, 0, 0, 3, 32'h8, 1, 0, 32'hDEAD};
    tbl[2]  = '{mkcs(0, RegSrcNone, MemSrcRsrc1, JmpNone, 3'd0), 32'h0, 32'h200,
                32'h1234, 32'h0, 32'h0, 0, 0, 2, 0, 32'hC, 1, 0, 32'hDEAD};
    tbl[3]  = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b010), 32'h0, 32'h0,
                32'h0, 32'h40, 32'h0, 0, 0, 0, 0, 32'h40, 1, 0, 32'hDEAD};
    tbl[4]  = '{mkcs(0, RegSrcAlu, MemSrcNone, JmpNone, 3'd0), 32'h5, 32'h0,
                32'h0, 32'h0, 32'h0, 2, 1, 0, 0, 32'h44, 0, 0, 32'hDEAD};
    tbl[5]  = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b010), 32'h0, 32'h0,
                32'h0, 32'h80, 32'h0, 0, 0, 0, 0, 32'h48, 0, 0, 32'hDEAD};
    tbl[6]  = '{mkcs(0, RegSrcAlu, MemSrcNone, JmpNone, 3'd0), 32'h80000000, 32'h0,
                32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h4C, 0, 1, 32'hDEAD};
    tbl[7]  = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b100), 32'h0, 32'h0,
                32'h0, 32'h100, 32'h0, 0, 0, 0, 0, 32'h100, 0, 1, 32'hDEAD};
    tbl[8]  = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b001), 32'h0, 32'h0,
                32'h0, 32'h200, 32'h0, 0, 0, 0, 0, 32'h104, 0, 1, 32'hDEAD};
    tbl[9]  = '{mkcs(0, RegSrcNone, MemSrcNone, JmpRsrc, 3'b110), 32'h0, 32'h0,
                32'h0, 32'h300, 32'h0, 0, 0, 0, 0, 32'h108, 0, 1, 32'hDEAD};
    tbl[10] = '{mkcs(0, RegSrcNone, MemSrcNone, JmpRsrc, 3'b000), 32'h0, 32'h0,
                32'h0, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 1, 32'hDEAD};
    tbl[11] = '{mkcs(0, RegSrcAlu, MemSrcNone, JmpNone, 3'd0), 32'h1, 32'h0,
                32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'hDEAD};
    tbl[12] = '{mkcs(0, RegSrcImm, MemSrcNone, JmpNone, 3'd0), 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h4, 0, 0, 32'hDEAD};
    tbl[13] = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b101), 32'h0, 32'h0,
                32'h0, 32'h500, 32'h0, 0, 0, 0, 0, 32'h500, 0, 0, 32'hDEAD};
    tbl[14] = '{mkcs(0, RegSrcNone, MemSrcNone, JmpImm, 3'b011), 32'h0, 32'h0,
                32'h0, 32'h600, 32'h0, 0, 2, 0, 0, 32'h600, 0, 0, 32'hDEAD};
    tbl[15] = '{mkcs(0, RegSrcMemory, MemSrcNone, JmpNone, 3'd0), 32'h0, 32'h604,
                32'h0, 32'h0, 32'h8000_0001, 3, 3, 1, 0, 32'h604, 0, 0, 32'h8000_0001};

    // Reset state, with the fetch request already visible during reset
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req_valid", mem_req_valid, 1'b1);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk1("rst_req_write", mem_req_write, 1'b0);
    chk1("rst_rf_we", rf_we, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    check_arch();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      run_instr(tbl[k].c, $urandom, tbl[k].alu, tbl[k].daddr, tbl[k].sdata, tbl[k].jtgt,
                tbl[k].rdata, tbl[k].rd1, tbl[k].rs1, tbl[k].rd2, tbl[k].rs2);
      chk("tbl_pc", pc, tbl[k].exp_pc);
      chk1("tbl_z", flag_z, tbl[k].exp_z);
      chk1("tbl_n", flag_n, tbl[k].exp_n);
      chk("tbl_mdr", mdr, tbl[k].exp_mdr);
    end

    // Randomized instruction stream against the reference model
    for (int k = 0; k < 60; k++) begin
      control_signal_t c;
      int kind;
      logic [31:0] alu;
      kind = $urandom_range(0, 4);
      alu  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      unique case (kind)
        0: c = mkcs(0, RegSrcAlu, MemSrcNone, JmpNone, 3'd0);
        1: c = mkcs(0, RegSrcImm, MemSrcNone, JmpNone, 3'd0);
        2: c = mkcs(0, RegSrcMemory, MemSrcNone, JmpNone, 3'd0);
        3: c = mkcs(0, RegSrcNone, MemSrcRsrc1, JmpNone, 3'd0);
        default: c = mkcs(0, RegSrcNone, MemSrcNone,
                          ($urandom_range(0, 1) != 0) ? JmpImm : JmpRsrc,
                          3'($urandom_range(0, 7)));
      endcase
      run_instr(c, $urandom, alu, $urandom, $urandom, {$urandom_range(0, 32'h3FFF), 2'b00},
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset mid-FETCH with ready low abandons the request and restarts at 0
    cs = mkcs(0, RegSrcNone, MemSrcNone, JmpNone, 3'd0);
    cyc(1, 0, m_pc, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk1("mid_rst_valid", mem_req_valid, 1'b1);
    chk("mid_rst_addr", mem_req_addr, 32'h0);
    check_arch();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", mem_req_addr, 32'h0);

    // hlt (opcode 0x03): halts after DECODE and stays quiet
    run_instr(mkcs(1, RegSrcNone, MemSrcNone, JmpNone, 3'd0), 32'h03000000,
              0, 0, 0, 0, 0, 1, 2, 0, 0);
    chk1("hlt_halted", halted, 1'b1);

    // Invalid opcode 0xFF: decoder flags halt, only reset leaves HALTED
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk1("rst_clears_halted", halted, 1'b0);
    run_instr(tbl[0].c, $urandom, 32'h9, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(mkcs(1, RegSrcNone, MemSrcNone, JmpNone, 3'd0), 32'hFF000000,
              0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("inv_pc", pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pisa_sequencer.md
# pisa_sequencer

Multi-cycle instruction sequencer for the PISA core. Owns the PC, instruction register, memory data register and Z/N flags. Drives a single shared memory port for both instruction fetch and load/store, using the decoder's `control_signal_t` to select each instruction's path. Sits between the memory interface and the datapath (register file, ALU) and produces every state-changing strobe for them.

## Interface
- `XLEN`, 32: data, address and instruction width.
- `RESET_PC`, 32'h0: PC value after reset.
- `INSTR_BYTES`, 4: PC increment for a non-taken instruction.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  `control_signal_t`  decoder output for the current `ir[XLEN-1:XLEN-8]`.
- `alu_result`  in  XLEN  ALU output for the current instruction.
- `data_addr`  in  XLEN  datapath-computed data address (immediate or rsrc2, per `cs.memory_address_src`).
- `store_data`  in  XLEN  rsrc1 value.
- `jump_target`  in  XLEN  datapath-computed target (per `cs.jmp_src`).
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_write`  out  1  1 = store.
- `mem_req_addr`  out  XLEN  request address.
- `mem_req_wdata`  out  XLEN  store data.
- `mem_rsp_valid`  in  1  read data valid.
- `mem_rsp_data`  in  XLEN  read data.
- `pc`  out  XLEN  program counter.
- `ir`  out  XLEN  instruction register.
- `mdr`  out  XLEN  last loaded data.
- `rf_we`  out  1  one-cycle register-file write strobe.
- `flag_z`, `flag_n`  out  1 each  zero and negative flags.
- `halted`  out  1  core stopped.

## Operation
- States: `FETCH`, `FETCH_WAIT`, `DECODE`, `EXECUTE`, `MEM`, `MEM_WAIT`, `WRITEBACK`, `HALTED`.
- `FETCH`: `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr`=`pc`. On `mem_req_ready`, go to `FETCH_WAIT`.
- `FETCH_WAIT`: on `mem_rsp_valid`, `ir`<=`mem_rsp_data` and go to `DECODE`.
- `DECODE`: one cycle; lets the decoder and datapath settle. If `cs.halt`, go to `HALTED`; otherwise go to `EXECUTE`.
- `EXECUTE`: if `cs.write_register_src`==MEMORY or `cs.write_memory_src`!=NONE, go to `MEM`; otherwise go to `WRITEBACK`.
- `MEM`: `mem_req_valid`=1 and `mem_req_addr`=`data_addr`. For a store, `mem_req_write`=1 and `mem_req_wdata`=`store_data`. On ready: a store goes to `WRITEBACK`, a load goes to `MEM_WAIT`.
- `MEM_WAIT`: on `mem_rsp_valid`, `mdr`<=`mem_rsp_data` and go to `WRITEBACK`.
- `WRITEBACK`:
  - `rf_we`=1 iff `cs.write_register_src`!=NONE.
  - If the source is ALU: `flag_z`<=(`alu_result`==0) and `flag_n`<=`alu_result[XLEN-1]`. No other source touches the flags.
  - `pc`<=`jump_target` if `cs.jmp_src`!=NONE and the condition holds; otherwise `pc`<=`pc`+`INSTR_BYTES`, modulo 2^XLEN (wraps).
  - Next state is `FETCH`.
- Jump condition from `cs.jump_condition`: ALWAYS=1, IF_ZERO=Z, IF_NOT_ZERO=!Z, IF_NEGATIVE=N, IF_NOT_NEGATIVE=!N. The undefined codes 001/110/111 mean not taken.
- `HALTED`: absorbing. No requests and no strobes; `halted`=1. Exit only via reset.
- Request rules:
  - Once asserted, `mem_req_valid`, `mem_req_addr`, `mem_req_write` and `mem_req_wdata` hold stable until ready.
  - `mem_rsp_valid` outside `FETCH_WAIT`/`MEM_WAIT` is ignored.
  - A response in the same cycle as ready is not accepted; a response is accepted no earlier than the cycle after ready.

## Timing
- Reset values: state `FETCH`, `pc`=`RESET_PC`, `ir`=0, `mdr`=0, `flag_z`=0, `flag_n`=0, `rf_we`=0, `halted`=0.
- Because state resets to `FETCH`, `mem_req_valid` is 1 combinationally during and after reset; the first request is issued at `RESET_PC`. An assertion of `rst_n` mid-request abandons the transaction, and the request restarts at `RESET_PC`.
- All outputs are registered or decoded from state only; no input-to-output combinational path except the held request fields.
- Zero-wait memory (ready=1, rsp next cycle):
  - ALU/jump instruction: 5 cycles (`FETCH`, `FETCH_WAIT`, `DECODE`, `EXECUTE`, `WRITEBACK`).
  - Store: 6 cycles. Load: 7 cycles.
- Each ready stall or rsp delay adds one cycle per cycle of delay.
- `pc` and flags update on the clock edge that ends `WRITEBACK`; the next `FETCH` uses the new `pc`.

## Structure
- Shared package `pisa_pkg`: the decoder's `control_signal_t` and its enums, plus the new `seq_state_t`.
- Sub-module `jump_cond_eval`: combinational; (`jump_condition`, Z, N) -> taken.
- The rest is one FSM plus the PC/IR/MDR/flag registers, with the address mux inline.

## Test plan
- Reset mid-`FETCH` with ready=0 -> after reset releases, `mem_req_valid`=1, addr=0, `pc`=0, all other outputs 0.
- ADD with `alu_result`=0, zero-wait memory -> `rf_we` pulses in cycle 5, `flag_z`=1, `flag_n`=0, `pc` 0->4.
- LODA with `data_addr`=0x100, rsp=0xDEAD after 3 wait cycles -> `mdr`=0xDEAD, `rf_we` pulse, 10 cycles total.
- STOA with ready held low 2 cycles -> addr/wdata/write stable throughout, no `rf_we`, `pc`+=4.
- JER (condition 010), `jump_target`=0x40: with Z=1 -> `pc`=0x40; with Z=0 -> `pc`+=4. JLR (100) with N=1 -> taken.
- Opcode 0x03 (hlt) and opcode 0xFF (invalid) -> `HALTED` after `DECODE`, `halted`=1, no further requests for 20 cycles.
